// File: rtl/dwt_pkg.sv
// Shared types and width helpers for the lifting-scheme DWT control, datapath and coefficient buffer.
package dwt_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    FLUSH,
    FEED,
    DONE
  } state_t;

  function automatic int cnt_width(input int n_samples);
    return $clog2(n_samples + 1);
  endfunction

  function automatic int lvl_width(input int levels);
    return (levels > 1) ? $clog2(levels) : 1;
  endfunction

endpackage

// File: rtl/dwt_phase_counter.sv
// Phase counter with synchronous clear, enable and terminal-value compare.
module dwt_phase_counter #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic [CNT_W-1:0] term_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             at_term_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o     = cnt_q;
  assign at_term_o = (cnt_q == term_i);

endmodule

// File: rtl/dwt_level_ctrl.sv
// Multi-level DWT sequencer: loads a frame, then alternates pipeline flushes and coarse-coefficient feeds per level.
module dwt_level_ctrl
  import dwt_pkg::*;
#(
  parameter int N_SAMPLES = 8,
  parameter int LEVELS    = 3,
  parameter int PIPE_LAT  = 3,
  localparam int CNT_W    = cnt_width(N_SAMPLES),
  localparam int LVL_W    = lvl_width(LEVELS)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             valid_in,
  input  logic             abort,
  output logic             in_ready,
  output logic             data_sel,
  output logic             internal_valid,
  output logic             coarse_rd_en,
  output logic [CNT_W-1:0] rd_addr,
  output logic [LVL_W-1:0] level_idx,
  output logic             level_done,
  output logic             frame_done,
  output logic             busy,
  output logic             err_overrun
);

  localparam logic [LVL_W-1:0] LVL_LAST  = LVL_W'(LEVELS - 1);
  localparam logic [CNT_W-1:0] LOAD_TERM = CNT_W'(N_SAMPLES - 1);
  localparam logic [CNT_W-1:0] PIPE_TERM = CNT_W'(PIPE_LAT - 1);

  state_t           state_q;
  logic [LVL_W-1:0] lvl_q;
  logic             ovr_q;

  logic             accept;
  logic             cnt_clr;
  logic             cnt_en;
  logic [CNT_W-1:0] cnt_term;
  logic [CNT_W-1:0] cnt;
  logic             at_term;
  logic [CNT_W-1:0] feed_term;

  // A sample arriving together with abort is dropped, not accepted.
  assign accept    = valid_in && in_ready && !abort;
  assign feed_term = CNT_W'((N_SAMPLES >> lvl_q) - 1);

  always_comb begin
    cnt_clr  = 1'b0;
    cnt_en   = 1'b0;
    cnt_term = '0;
    unique case (state_q)
      IDLE: begin
        cnt_en = accept;
      end
      LOAD: begin
        cnt_term = LOAD_TERM;
        if (accept) begin
          cnt_clr = at_term;
          cnt_en  = !at_term;
        end
      end
      FLUSH: begin
        cnt_term = PIPE_TERM;
        cnt_clr  = at_term;
        cnt_en   = !at_term;
      end
      FEED: begin
        cnt_term = feed_term;
        cnt_clr  = at_term;
        cnt_en   = !at_term;
      end
      DONE: begin
        cnt_clr = 1'b1;
      end
      default: begin
        cnt_clr = 1'b1;
      end
    endcase
    if (abort) begin
      cnt_clr = 1'b1;
      cnt_en  = 1'b0;
    end
  end

  dwt_phase_counter #(
    .CNT_W(CNT_W)
  ) u_phase_cnt (
    .clk      (clk),
    .reset    (reset),
    .clr_i    (cnt_clr),
    .en_i     (cnt_en),
    .term_i   (cnt_term),
    .cnt_o    (cnt),
    .at_term_o(at_term)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      lvl_q   <= '0;
      ovr_q   <= 1'b0;
    end else begin
      ovr_q <= valid_in && !in_ready;
      if (abort) begin
        state_q <= IDLE;
        lvl_q   <= '0;
      end else begin
        unique case (state_q)
          IDLE: begin
            if (accept) begin
              state_q <= LOAD;
              lvl_q   <= '0;
            end
          end
          LOAD: begin
            if (accept && at_term) state_q <= FLUSH;
          end
          FLUSH: begin
            if (at_term) begin
              if (lvl_q == LVL_LAST) begin
                state_q <= DONE;
              end else begin
                lvl_q   <= lvl_q + LVL_W'(1);
                state_q <= FEED;
              end
            end
          end
          FEED: begin
            if (at_term) state_q <= FLUSH;
          end
          DONE: begin
            state_q <= IDLE;
            lvl_q   <= '0;
          end
          default: begin
            state_q <= IDLE;
            lvl_q   <= '0;
          end
        endcase
      end
    end
  end

  assign in_ready       = (state_q == IDLE) || (state_q == LOAD);
  assign data_sel       = (state_q == FEED) || ((state_q == FLUSH) && (lvl_q != '0));
  assign internal_valid = (state_q == FEED);
  assign coarse_rd_en   = (state_q == FEED);
  assign rd_addr        = (state_q == FEED) ? cnt : '0;
  assign level_idx      = lvl_q;
  assign level_done     = (state_q == FLUSH) && at_term;
  assign frame_done     = (state_q == DONE);
  assign busy           = (state_q != IDLE);
  assign err_overrun    = ovr_q;

endmodule
